// File: rtl/debug_pkg.sv
// debug_pkg: shared FSM states, dump item ranges and word totals for debug_dump_tx.
// DUMP_LATCHES_EN appends the pipeline-latch words to the dump sequence.
package debug_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_CAPTURE, S_SEND, S_WAIT, S_DONE} state_t;
  localparam int PC_IDX = 0;
  localparam int CLK_IDX = 1;
  localparam int REG_BASE = 2;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_MEM_DATA = 16;
  localparam int DEF_NUM_LATCH = 15;
`ifdef DUMP_LATCHES_EN
  localparam bit LATCH_EN = 1'b1;
`else
  localparam bit LATCH_EN = 1'b0;
`endif
  function automatic int mem_base(input int nregs);
    return REG_BASE + nregs;
  endfunction
  function automatic int latch_base(input int nregs, input int nmem);
    return REG_BASE + nregs + nmem;
  endfunction
  function automatic int word_total(input int nregs, input int nmem, input int nlatch);
    return REG_BASE + nregs + nmem + nlatch;
  endfunction
  localparam int MEM_BASE = mem_base(DEF_NUM_REGS);
  localparam int LATCH_BASE = latch_base(DEF_NUM_REGS, DEF_MEM_DATA);
  localparam int NUM_WORDS = word_total(DEF_NUM_REGS, DEF_MEM_DATA, LATCH_EN ? DEF_NUM_LATCH : 0);
endpackage

// File: rtl/dump_word_mux.sv
// dump_word_mux: picks the word for item i_k and the select addresses for item i_k_nxt.
// DUMP_LATCHES_EN adds the latch range after data memory.
module dump_word_mux
  import debug_pkg::*;
#(
  parameter int BITS_SIZE = 32,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SIZE_MEM_DATA = DEF_MEM_DATA,
  parameter int KW = 6
) (
  input  logic [KW-1:0]               i_k,
  input  logic [KW-1:0]               i_k_nxt,
  input  logic [BITS_SIZE-1:0]        i_pc,
  input  logic [BITS_SIZE-1:0]        i_clk_count,
  input  logic [BITS_SIZE-1:0]        i_reg_data,
  input  logic [BITS_SIZE-1:0]        i_mem_data,
  input  logic [BITS_SIZE-1:0]        i_latch_data,
  output logic [BITS_SIZE-1:0]        o_word,
  output logic                        o_reg_hit,
  output logic                        o_mem_hit,
  output logic                        o_latch_hit,
  output logic [$clog2(NUM_REGS)-1:0] o_reg_idx,
  output logic [BITS_SIZE-1:0]        o_mem_idx,
  output logic [3:0]                  o_latch_idx
);
  localparam int RW = $clog2(NUM_REGS);
  localparam logic [KW-1:0] PC_K = KW'(PC_IDX);
  localparam logic [KW-1:0] CLK_K = KW'(CLK_IDX);
  localparam logic [KW-1:0] RB = KW'(REG_BASE);
  localparam logic [KW-1:0] MB = KW'(mem_base(NUM_REGS));
  assign o_reg_hit = (i_k_nxt >= RB) && (i_k_nxt < MB);
  assign o_reg_idx = RW'(i_k_nxt - RB);
  assign o_mem_idx = BITS_SIZE'(i_k_nxt - MB);
`ifdef DUMP_LATCHES_EN
  localparam logic [KW-1:0] LB = KW'(latch_base(NUM_REGS, SIZE_MEM_DATA));
  assign o_mem_hit = (i_k_nxt >= MB) && (i_k_nxt < LB);
  assign o_latch_hit = i_k_nxt >= LB;
  assign o_latch_idx = 4'(i_k_nxt - LB);
  assign o_word = (i_k == PC_K)  ? i_pc :
                  (i_k == CLK_K) ? i_clk_count :
                  (i_k < MB)     ? i_reg_data :
                  (i_k < LB)     ? i_mem_data : i_latch_data;
`else
  logic w_unused;
  assign w_unused = ^i_latch_data;
  assign o_mem_hit = i_k_nxt >= MB;
  assign o_latch_hit = 1'b0;
  assign o_latch_idx = '0;
  assign o_word = (i_k == PC_K)  ? i_pc :
                  (i_k == CLK_K) ? i_clk_count :
                  (i_k < MB)     ? i_reg_data : i_mem_data;
`endif
endmodule

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: walks PC, clock count, registers, data memory (and latches with
// DUMP_LATCHES_EN) and streams each 32-bit word LSB-first to the UART transmitter.
module debug_dump_tx
  import debug_pkg::*;
#(
  parameter int BITS_SIZE = 32,
  parameter int SIZE_TRAMA = 8,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SIZE_MEM_DATA = DEF_MEM_DATA,
  parameter int NUM_LATCH = DEF_NUM_LATCH
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [BITS_SIZE-1:0]        i_pc,
  input  logic [BITS_SIZE-1:0]        i_clk_count,
  input  logic [BITS_SIZE-1:0]        i_reg_data,
  input  logic [BITS_SIZE-1:0]        i_mem_data,
  input  logic [BITS_SIZE-1:0]        i_latch_data,
  input  logic                        i_tx_done,
  output logic [$clog2(NUM_REGS)-1:0] o_sel_reg,
  output logic [BITS_SIZE-1:0]        o_sel_mem,
  output logic [3:0]                  o_sel_latch,
  output logic                        o_tx_start,
  output logic [SIZE_TRAMA-1:0]       o_tx_data,
  output logic                        o_busy,
  output logic                        o_done
);
  localparam int W = word_total(NUM_REGS, SIZE_MEM_DATA, LATCH_EN ? NUM_LATCH : 0);
  localparam int KW = $clog2(W);
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);
  localparam logic [1:0] LAST_B = 2'(BITS_SIZE / SIZE_TRAMA - 1);
  state_t r_state;
  logic [KW-1:0] r_k;
  logic [1:0] r_cnt;
  logic [BITS_SIZE-1:0] r_shift;
  logic [KW-1:0] w_k_nxt;
  logic w_last_byte, w_next_word, w_to_sel;
  logic [BITS_SIZE-1:0] w_word, w_mem_idx;
  logic w_reg_hit, w_mem_hit, w_latch_hit;
  logic [$clog2(NUM_REGS)-1:0] w_reg_idx;
  logic [3:0] w_latch_idx;
  assign w_last_byte = (r_state == S_WAIT) && i_tx_done && (r_cnt == LAST_B);
  assign w_next_word = w_last_byte && (r_k != K_LAST);
  assign w_to_sel = ((r_state == S_IDLE) && i_start) || w_next_word;
  assign w_k_nxt = (r_state == S_IDLE) ? '0 : r_k + KW'(1);
  dump_word_mux #(
    .BITS_SIZE(BITS_SIZE),
    .NUM_REGS(NUM_REGS),
    .SIZE_MEM_DATA(SIZE_MEM_DATA),
    .KW(KW)
  ) u_mux (
    .i_k(r_k),
    .i_k_nxt(w_k_nxt),
    .i_pc(i_pc),
    .i_clk_count(i_clk_count),
    .i_reg_data(i_reg_data),
    .i_mem_data(i_mem_data),
    .i_latch_data(i_latch_data),
    .o_word(w_word),
    .o_reg_hit(w_reg_hit),
    .o_mem_hit(w_mem_hit),
    .o_latch_hit(w_latch_hit),
    .o_reg_idx(w_reg_idx),
    .o_mem_idx(w_mem_idx),
    .o_latch_idx(w_latch_idx)
  );
  // Selects move on the edge entering SELECT so read data settles before CAPTURE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_k <= '0;
      r_cnt <= '0;
      r_shift <= '0;
      o_sel_reg <= '0;
      o_sel_mem <= '0;
      o_sel_latch <= '0;
      o_tx_start <= 1'b0;
      o_tx_data <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done <= 1'b0;
      if (w_to_sel) begin
        r_k <= w_k_nxt;
        if (w_reg_hit) o_sel_reg <= w_reg_idx;
        if (w_mem_hit) o_sel_mem <= w_mem_idx;
        if (w_latch_hit) o_sel_latch <= w_latch_idx;
      end
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_SELECT;
          o_busy <= 1'b1;
        end
        S_SELECT: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_shift <= w_word;
          r_cnt <= '0;
          o_tx_data <= w_word[SIZE_TRAMA-1:0];
          o_tx_start <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: r_state <= S_WAIT;
        S_WAIT: if (i_tx_done) begin
          if (r_cnt != LAST_B) begin
            r_shift <= r_shift >> SIZE_TRAMA;
            r_cnt <= r_cnt + 2'd1;
            o_tx_data <= r_shift[2*SIZE_TRAMA-1:SIZE_TRAMA];
            o_tx_start <= 1'b1;
            r_state <= S_SEND;
          end else if (r_k != K_LAST) begin
            r_state <= S_SELECT;
          end else begin
            o_done <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/debug_dump_tx.md
# debug_dump_tx

Debug dump serializer for the MIPS debug path. When the debug controller requests a dump, this block walks the processor's observable state in a fixed order: PC, clock count, register bank, data memory, and optionally the pipeline latches. It drives the select addresses, captures each 32-bit word, splits it into bytes LSB-first, and hands each byte to the UART transmitter with a start/done handshake. It sits between the debug unit and the UART TX, mirroring the byte-to-instruction-word loader on the RX side.

## Interface
- BITS_SIZE, 32, word width of every dumped item
- SIZE_TRAMA, 8, UART byte width
- NUM_REGS, 32, register-bank entries dumped
- SIZE_MEM_DATA, 16, data-memory words dumped
- NUM_LATCH, 15, pipeline-latch words dumped (only with DUMP_LATCHES_EN)

Ports:
- i_clk  in  1  single clock; all logic on posedge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  dump request; sampled only in IDLE
- i_pc  in  BITS_SIZE  current PC
- i_clk_count  in  BITS_SIZE  stepped-clock counter
- i_reg_data  in  BITS_SIZE  register-bank read data for o_sel_reg
- i_mem_data  in  BITS_SIZE  data-memory read data for o_sel_mem
- i_latch_data  in  BITS_SIZE  latch word for o_sel_latch
- i_tx_done  in  1  one-cycle pulse from UART TX: byte finished
- o_sel_reg  out  $clog2(NUM_REGS)  register address
- o_sel_mem  out  BITS_SIZE  data-memory word address
- o_sel_latch  out  4  latch index, 0..NUM_LATCH-1
- o_tx_start  out  1  one-cycle pulse: send o_tx_data
- o_tx_data  out  SIZE_TRAMA  byte to transmit
- o_busy  out  1  high from accepted start until DONE
- o_done  out  1  one-cycle pulse after the last byte's i_tx_done

## Operation
- The dump sequence uses an index k over these items, in order:
  - k=0: PC
  - k=1: clk_count
  - k=2..33: reg 0..31
  - next SIZE_MEM_DATA items: mem 0..15
  - next NUM_LATCH items: latches, only when configured
- Total words W = 2+NUM_REGS+SIZE_MEM_DATA (+NUM_LATCH). With defaults W=50 (65 with latches). Bytes sent = 4·W.
- Each word is sent as 4 bytes: [7:0], [15:8], [23:16], [31:24].
- FSM states and transitions:
  - IDLE: on i_start go to SELECT and raise o_busy.
  - SELECT: drive the select address for k, then go to CAPTURE.
  - CAPTURE: latch the mux output into the 32-bit shift register, clear the byte count to 0, then go to SEND.
  - SEND: pulse o_tx_start with o_tx_data = shift[7:0], then go to WAIT.
  - WAIT: hold o_tx_data. On i_tx_done:
    - if byte count < 3: shift right by 8, increment byte count, go to SEND.
    - if byte count = 3 and k < W-1: increment k, go to SELECT.
    - if byte count = 3 and k = W-1: go to DONE.
  - DONE: pulse o_done, drop o_busy, go to IDLE.
- Selects not addressed by the current item hold their last value. Register and memory reads are combinational at the MIPS side and must be valid one cycle after the select is driven.
- i_start while busy: ignored, no queueing.
- i_tx_done outside WAIT: ignored.
- Reset in any state: return to IDLE next edge, all outputs and counters to zero.

## Timing
- Reset values: o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, all o_sel_*=0, k=0.
- All outputs are registered.
- i_start high at edge N gives: o_busy=1 and select valid after N; word captured at N+2; o_tx_start high during cycle N+3 with byte 0.
- i_tx_done at edge M gives the next o_tx_start in cycle M+1 (same word) or M+3 (next word).
- o_tx_data is stable from o_tx_start until i_tx_done.
- Last byte's i_tx_done at edge M gives o_done during cycle M+1 and o_busy=0 from M+2.

## Configuration
- DUMP_LATCHES_EN
  - Defined: the NUM_LATCH latch words follow data memory, and o_sel_latch steps 0..14.
  - Undefined: the sequence ends after data memory (W=50), o_sel_latch is tied to 0, and i_latch_data is unused.

## Structure
- Shared package debug_pkg holds:
  - the FSM state enum
  - item-range base constants (PC_IDX, CLK_IDX, REG_BASE, MEM_BASE, LATCH_BASE)
  - the computed word total
- One sub-module, dump_word_mux: combinational selection of the current word from k and the data inputs. It also produces the o_sel_* values.

## Test plan
- Reset during WAIT of byte 2 of reg 5 -> next cycle all outputs 0. A new i_start restarts at PC byte 0.
- PC=0x12345678, clk_count=0x0000000A, with an immediate i_tx_done model -> first 8 bytes are 78 56 34 12 0A 00 00 00.
- Reg k holds 0x100+k, mem j holds 0xA000+j -> byte stream matches, 200 bytes total, o_done once, o_sel_reg sweeps 0..31.
- i_tx_done delayed by 1000 cycles -> o_tx_data stable throughout, o_tx_start exactly one pulse per byte.
- i_start pulsed mid-dump, plus spurious i_tx_done in SELECT -> byte count and order unchanged.
- With DUMP_LATCHES_EN, latch i = 0xC0DE0000+i -> 260 bytes, with the latch words after mem 15.
